seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
Parametrised successor to the 8-digit seven-segment controller. Time-multiplexes DIGITS hex digits onto one shared 8-bit segment bus with one anode select per digit. Adds a programmable refresh prescaler, per-frame shadow buffering (no tearing when inputs change mid-scan), PWM brightness control, selectable output polarity and a frame-done strobe. Sits between user/debug logic and the board's seven-segment pins.

Parameters:
DIGITS, 8, number of multiplexed digits (1..16).
CLK_DIV, 100000, clk cycles per digit slot (>=2).
BRIGHT_W, 4, width of the brightness input.
ACTIVE_LOW, 1, 1 = pos and segments are driven active-low at the pins; 0 = active-high.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
digit  input  4*DIGITS  hex value of digit i on digit[4i+3:4i].
en_dot  input  DIGITS  decimal point enable per digit.
en_digit  input  DIGITS  digit enable per digit; 0 blanks that digit.
brightness  input  BRIGHT_W  PWM duty; 0 = dark, all-ones = (2^BRIGHT_W-1)/2^BRIGHT_W.
pos  output  DIGITS  anode select; pos[i] drives digit i.
segments  output  8  bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- All logic internal active-high; pos/segments inverted at the output register when ACTIVE_LOW=1.
- Reset (asynchronous): prescaler=0, index=0, pwm_cnt=0, shadow registers=0, loaded=0, frame_done=0; pos and segments all inactive (all-ones when ACTIVE_LOW=1, all-zeros otherwise).
- Prescaler counts 0..CLK_DIV-1. tick = (prescaler == CLK_DIV-1); on tick, prescaler returns to 0 and index increments, wrapping DIGITS-1 -> 0.
- pwm_cnt: BRIGHT_W-bit free-running counter, +1 every cycle, natural wrap.
- Shadow load: digit, en_dot, en_digit and brightness are copied into shadow registers on the first cycle after reset release (loaded=0 -> 1) and on every tick with index==DIGITS-1. Displayed values change only at these points.
- frame_done = 1 for exactly the cycle after a tick with index==DIGITS-1 (registered together with the wrap). No pulse for the post-reset load.
- lit = shadow_en_digit[index] && (pwm_cnt < shadow_brightness).
- Outputs are registered from the current state, so 1-cycle latency: pos/segments at cycle n+1 reflect index/pwm_cnt/shadow at cycle n.
- lit: pos = one-hot(index) active; segments[6:0] = hex font of shadow digit, segments[7] = shadow_en_dot[index].
- not lit: pos all inactive, segments all inactive.
- Hex font, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Never more than one pos bit active in any cycle.
- Input changes between shadow loads have no visible effect. rst mid-frame blanks outputs immediately and restarts at index 0.

Optional Feature:
SEVEN_SEG_LZ_BLANK_EN: when defined, leading-zero suppression applies to shadow values. Scanning from index DIGITS-1 down, each digit with value 0 and dot disabled is blanked (treated as en_digit=0) until the first non-zero or dotted digit. Digit 0 is never blanked. When undefined, zeros display normally and shadow en_digit alone controls blanking.

Test Plan:
- Bench config: DIGITS=8, CLK_DIV=4, BRIGHT_W=2, ACTIVE_LOW=1.
- Reset, all digits F, en_digit=FF, en_dot=00, brightness=3 -> while rst=1: pos=FF, segments=FF. After release, each index holds 4 cycles. Slot 0 shows pos=FE, segments=8E for 3 of every 4 cycles (pwm_cnt=3 dark). Order FE,FD,FB..7F, then wrap with frame_done pulsing once per 32 cycles.
- Mid-frame, set digit[31:28]=5 and digit[3:0]=0 -> old values until next frame_done. Then slot 7 shows segments=92 and slot 0 shows segments=C0.
- en_digit=EF, en_dot=01 -> slot 4 pos=FF, segments=FF. Slot 0 has segments bit7=0 (dp lit).
- brightness=0 -> pos stays FF for a full frame. brightness=1 -> each slot lit exactly 1 of 4 cycles.
- With SEVEN_SEG_LZ_BLANK_EN, digit=0000_0120, en_dot=00, en_digit=FF -> slots 7..3 dark. Slots 2,1,0 show 1,2,0 (segments F9,A4,C0). digit=0 -> only slot 0 lit, showing C0.
- Assert rst mid-slot 5 -> outputs inactive the same cycle (asynchronous). After release, scan restarts at slot 0 and frame_done stays low until the first full frame completes.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// ----------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexes DIGITS hex digits onto one shared segment bus with one
// anode select per digit. A prescaler sets how long each digit slot lasts,
// a free-running counter gives PWM brightness, and all display inputs are
// captured into shadow registers once per frame so a scan never tears.
//
// Optional build macro:
//   SEVEN_SEG_LZ_BLANK_EN  - blank leading zeros of the shadowed value
//                            (scanning down from the top digit; digit 0 is
//                            never blanked, a dotted digit stops blanking).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   digit       in   4*DIGITS  hex value of digit i on digit[4i+3:4i]
//   en_dot      in   DIGITS    decimal point enable per digit
//   en_digit    in   DIGITS    digit enable per digit (0 blanks it)
//   brightness  in   BRIGHT_W  PWM duty, 0 = dark
//   pos         out  DIGITS    anode select, pos[i] drives digit i
//   segments    out  8         bit7 = dp, bits6..0 = g,f,e,d,c,b,a
//   frame_done  out  1         one-cycle pulse at each frame wrap
// ----------------------------------------------------------------------------
module seven_segment_scanner #(
    parameter int DIGITS     = 8,
    parameter int CLK_DIV    = 100000,
    parameter int BRIGHT_W   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit,
    input  logic [DIGITS-1:0]     en_dot,
    input  logic [DIGITS-1:0]     en_digit,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     pos,
    output logic [7:0]            segments,
    output logic                  frame_done
);

    localparam int PRE_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // Pin-level "off" patterns; XOR with these converts active-high to pins.
    localparam logic [DIGITS-1:0] POS_OFF = {DIGITS{ACTIVE_LOW != 0}};
    localparam logic [7:0]        SEG_OFF = {8{ACTIVE_LOW != 0}};

    logic [PRE_W-1:0]    prescaler;
    logic [IDX_W-1:0]    index;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic                loaded;

    logic [4*DIGITS-1:0] sh_digit;
    logic [DIGITS-1:0]   sh_dot;
    logic [DIGITS-1:0]   sh_en;
    logic [BRIGHT_W-1:0] sh_bright;

    logic                tick;
    logic                frame_wrap;
    logic                load;

    logic [DIGITS-1:0]   eff_en;
    logic [3:0]          cur_val;
    logic                cur_dot;
    logic                cur_en;
    logic [DIGITS-1:0]   cur_onehot;
    logic                lit;
    logic [DIGITS-1:0]   pos_next;
    logic [7:0]          seg_next;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h3F;
            4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;
            4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;
            4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;
            4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;
            4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;
            4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;
            4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

    assign tick       = (prescaler == PRE_LAST);
    assign frame_wrap = tick && (index == IDX_LAST);
    // First cycle after reset also loads, so the display does not sit blank
    // for a whole frame waiting for the first wrap.
    assign load       = !loaded || frame_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            index      <= '0;
            pwm_cnt    <= '0;
            loaded     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + BRIGHT_W'(1);
            loaded     <= 1'b1;
            frame_done <= frame_wrap;
            if (tick) begin
                prescaler <= '0;
                index     <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_digit  <= '0;
            sh_dot    <= '0;
            sh_en     <= '0;
            sh_bright <= '0;
        end else if (load) begin
            sh_digit  <= digit;
            sh_dot    <= en_dot;
            sh_en     <= en_digit;
            sh_bright <= brightness;
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic [DIGITS-1:0] lz_blank;
    logic              lz_leading;

    // Walk down from the top digit; blanking stops at the first digit that
    // is non-zero or has its dot on. Loop stops at 1 so digit 0 always shows.
    always_comb begin
        lz_leading = 1'b1;
        lz_blank   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lz_leading && (sh_digit[4*i +: 4] == 4'h0) && !sh_dot[i]) begin
                lz_blank[i] = 1'b1;
            end else begin
                lz_leading = 1'b0;
            end
        end
    end

    assign eff_en = sh_en & ~lz_blank;
`else
    assign eff_en = sh_en;
`endif

    always_comb begin
        cur_val    = '0;
        cur_dot    = 1'b0;
        cur_en     = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (index == IDX_W'(i)) begin
                cur_val       = sh_digit[4*i +: 4];
                cur_dot       = sh_dot[i];
                cur_en        = eff_en[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    assign lit = cur_en && (pwm_cnt < sh_bright);

    always_comb begin
        pos_next = '0;
        seg_next = '0;
        if (lit) begin
            pos_next = cur_onehot;
            seg_next = {cur_dot, hex_font(cur_val)};
        end
    end

    // Polarity applied at the output register so the pins are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= POS_OFF;
            segments <= SEG_OFF;
        end else begin
            pos      <= pos_next ^ POS_OFF;
            segments <= seg_next ^ SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

    localparam int DIGITS     = 8;
    localparam int CLK_DIV    = 4;
    localparam int BRIGHT_W   = 2;
    localparam int ACTIVE_LOW = 1;
    localparam int FRAME      = DIGITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digit;
    logic [7:0]  en_dot;
    logic [7:0]  en_digit;
    logic [1:0]  brightness;
    logic [7:0]  pos;
    logic [7:0]  segments;
    logic        frame_done;

    seven_segment_scanner #(
        .DIGITS    (DIGITS),
        .CLK_DIV   (CLK_DIV),
        .BRIGHT_W  (BRIGHT_W),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digit     (digit),
        .en_dot    (en_dot),
        .en_digit  (en_digit),
        .brightness(brightness),
        .pos       (pos),
        .segments  (segments),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pos;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int fd_cnt;
    int lit_cnt;

    // Active-low pin patterns for hex 0..F, dp off.
    logic [7:0] font_al [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lz_mask(input logic [31:0] d, input logic [7:0] dt);
        logic [7:0] m;
        int k;
        m = '0;
        k = DIGITS - 1;
        while (k > 0 && d[4*k +: 4] == 4'h0 && !dt[k]) begin
            m[k] = 1'b1;
            k--;
        end
        return m;
    endfunction

    // Reference model: everything derived from cycles since reset release.
    int          m_cyc;
    int          m_idx;
    int          m_ph;
    logic [31:0] s_digit;
    logic [7:0]  s_dot;
    logic [7:0]  s_en;
    logic [1:0]  s_bright;
    logic [7:0]  m_en;
    logic        m_lit;
    exp_t        m_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc    = 0;
            s_digit  = '0;
            s_dot    = '0;
            s_en     = '0;
            s_bright = '0;
            sb.delete();
        end else begin
            m_idx = (m_cyc / CLK_DIV) % DIGITS;
            m_ph  = m_cyc % (1 << BRIGHT_W);
            m_en  = s_en;
`ifdef SEVEN_SEG_LZ_BLANK_EN
            m_en  = s_en & ~lz_mask(s_digit, s_dot);
`endif
            m_lit    = m_en[m_idx] && (m_ph < int'(s_bright));
            m_e.pos  = m_lit ? ~(8'd1 << m_idx) : 8'hFF;
            m_e.seg  = m_lit ? (font_al[s_digit[4*m_idx +: 4]] & (s_dot[m_idx] ? 8'h7F : 8'hFF))
                             : 8'hFF;
            m_e.fd   = (m_cyc % FRAME) == FRAME - 1;
            sb.push_back(m_e);
            if (m_cyc == 0 || (m_cyc % FRAME) == FRAME - 1) begin
                s_digit  = digit;
                s_dot    = en_dot;
                s_en     = en_digit;
                s_bright = brightness;
            end
            m_cyc++;
        end
    end

    exp_t got_e;

    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            got_e = sb.pop_front();
            chk("pos", pos, got_e.pos);
            chk("seg", segments, got_e.seg);
            chk("frame_done", frame_done, got_e.fd);
            chk("onehot", $countones(~pos) <= 1, 1);
        end
    end

    task automatic run(input int n);
        fd_cnt  = 0;
        lit_cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (pos != 8'hFF) lit_cnt++;
        end
    endtask

    initial begin
        digit      = 32'hFFFF_FFFF;
        en_digit   = 8'hFF;
        en_dot     = 8'h00;
        brightness = 2'd3;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pos", pos, 8'hFF);
        chk("rst_seg", segments, 8'hFF);
        chk("rst_fd", frame_done, 0);

        rst = 1'b0;
        run(64);
        chk("fd_count_2frames", fd_cnt, 2);
        chk("lit_count_2frames", lit_cnt, 47);

        run(13);
        digit[31:28] = 4'h5;
        digit[3:0]   = 4'h0;
        run(70);

        en_digit = 8'hEF;
        en_dot   = 8'h01;
        run(70);

        brightness = 2'd0;
        run(70);
        brightness = 2'd1;
        run(70);
        brightness = 2'd3;
        run(40);

`ifdef SEVEN_SEG_LZ_BLANK_EN
        digit    = 32'h0000_0120;
        en_dot   = 8'h00;
        en_digit = 8'hFF;
        run(70);
        digit = 32'h0;
        run(70);
`endif

        // Asynchronous reset in the middle of slot 5.
        rst = 1'b1;
        @(negedge clk);
        digit      = 32'hFFFF_FFFF;
        en_digit   = 8'hFF;
        en_dot     = 8'h00;
        brightness = 2'd3;
        @(negedge clk);
        rst = 1'b0;
        run(22);
        chk("slot5_pos", pos, 8'hDF);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pos", pos, 8'hFF);
        chk("async_rst_seg", segments, 8'hFF);
        chk("async_rst_fd", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        run(31);
        chk("no_fd_first_frame", fd_cnt, 0);
        run(1);
        chk("fd_at_first_wrap", fd_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
